feedback_frame_decoder: RTL and testbench

Receive-side decoder for the GenshinKitchen → board direction of the UART link. It consumes bytes from the UART receive interface, ignores them while ScriptMem is loading, and decodes feedback bytes into the four player/machine status signals. Outputs are registered and confirmed, and the block flags the feedback as stale when the game stops reporting. The four status signals drive both operate-verification instances.

---
 rtl/feedback_frame_decoder.sv | 152 +++++++++++++++
 tb/tb_feedback_frame_decoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/feedback_frame_decoder.sv
// Purpose : decodes GenshinKitchen feedback bytes from the UART RX into four confirmed status bits plus health flags.
// Latency : status outputs update on the clock edge that accepts the confirming byte (1 cycle from data_valid rising).
// Backpressure: none; bytes are taken on the data_valid rising edge and can never be stalled.
//
// Ports:
//   uart_clk, reset        - the only clock; asynchronous active-low reset
//   data_valid/receive     - UART receive byte and its valid strobe
//   script_mode            - bytes are script data, not feedback, while high
//   tick_ms                - 1 ms pulse for the staleness timer
//   sig_*                  - confirmed status nibble (front, hand, processing, machine)
//   feedback_valid/stale   - {valid, stale} is the decoder state encoding itself
//   feedback_changed       - one-cycle pulse when the confirmed nibble changes
//   frame_count            - accepted feedback bytes, wraps
//   error_count            - rejected bytes, saturates at 255
module feedback_frame_decoder #(
    parameter int CONFIRM    = 1,
    parameter int TIMEOUT_MS = 500
) (
    input  logic       uart_clk,
    input  logic       reset,
    input  logic       data_valid,
    input  logic [7:0] data_receive,
    input  logic       script_mode,
    input  logic       tick_ms,
    output logic       sig_front,
    output logic       sig_hand,
    output logic       sig_processing,
    output logic       sig_machine,
    output logic       feedback_valid,
    output logic       feedback_stale,
    output logic       feedback_changed,
    output logic [7:0] frame_count,
    output logic [7:0] error_count
);

    // State encoding doubles as the {feedback_valid, feedback_stale} outputs.
    typedef enum logic [1:0] {
        NO_FB = 2'b00,
        LIVE  = 2'b10,
        STALE = 2'b11
    } state_e;

    localparam logic [3:0]  CONF_W = 4'(CONFIRM);
    localparam logic [15:0] TMO_W  = 16'(TIMEOUT_MS);

    state_e      state_q, state_d;
    logic        dv_q;
    logic [3:0]  cand_q, cand_d;
    logic [3:0]  match_q, match_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  status_q, status_d;
    logic        changed_q, changed_d;
    logic [7:0]  frame_q, frame_d;
    logic [7:0]  error_q, error_d;

    logic       byte_take;
    logic       fb_take;
    logic       rej_take;
    logic       commit;
    logic [3:0] payload;
    logic       unused_hi_bits;

    // Bits [7:6] carry no information for this block.
    assign unused_hi_bits = ^data_receive[7:6];

    always_comb begin
        byte_take = data_valid & ~dv_q & ~script_mode;
        fb_take   = byte_take & (data_receive[1:0] == 2'b01);
        rej_take  = byte_take & (data_receive[1:0] != 2'b01);
        payload   = data_receive[5:2];   // {machine, processing, hand, front}

        state_d   = state_q;
        cand_d    = cand_q;
        match_d   = match_q;
        timer_d   = timer_q;
        status_d  = status_q;
        changed_d = 1'b0;
        frame_d   = frame_q;
        error_d   = error_q;
        commit    = 1'b0;

        if (fb_take) begin
            frame_d = frame_q + 8'd1;
            if (payload == cand_q) begin
                if (match_q < CONF_W) begin
                    match_d = match_q + 4'd1;
                end
            end else begin
                cand_d  = payload;
                match_d = 4'd1;
            end
            // A saturated match count re-commits the same nibble on every
            // repeat; the change pulse filters out those no-op commits.
            commit = (match_d == CONF_W);
        end

        if (commit) begin
            status_d  = payload;
            changed_d = (state_q == NO_FB) || (payload != status_q);
        end

        if (rej_take && (error_q != 8'hFF)) begin
            error_d = error_q + 8'd1;
        end

        // A feedback byte clears the timer even when tick_ms fires in the same cycle.
        if (fb_take) begin
            timer_d = 16'd0;
        end else if ((state_q != NO_FB) && tick_ms && (timer_q != TMO_W)) begin
            timer_d = timer_q + 16'd1;
        end

        case (state_q)
            NO_FB:   if (commit)            state_d = LIVE;
            LIVE:    if (timer_d == TMO_W)  state_d = STALE;
            STALE:   if (fb_take)           state_d = LIVE;
            default:                        state_d = NO_FB;
        endcase
    end

    always_ff @(posedge uart_clk or negedge reset) begin
        if (!reset) begin
            state_q   <= NO_FB;
            dv_q      <= 1'b0;
            cand_q    <= 4'd0;
            match_q   <= 4'd0;
            timer_q   <= 16'd0;
            status_q  <= 4'd0;
            changed_q <= 1'b0;
            frame_q   <= 8'd0;
            error_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            dv_q      <= data_valid;
            cand_q    <= cand_d;
            match_q   <= match_d;
            timer_q   <= timer_d;
            status_q  <= status_d;
            changed_q <= changed_d;
            frame_q   <= frame_d;
            error_q   <= error_d;
        end
    end

    assign {sig_machine, sig_processing, sig_hand, sig_front} = status_q;
    assign feedback_valid   = state_q[1];
    assign feedback_stale   = state_q[0];
    assign feedback_changed = changed_q;
    assign frame_count      = frame_q;
    assign error_count      = error_q;

endmodule

// File: tb/tb_feedback_frame_decoder.sv
// Bench for feedback_frame_decoder: three instances (CONFIRM = 1, 3, 2; TIMEOUT_MS = 4)
// share one stimulus stream; each is compared every cycle to a per-instance reference model.
// Directed table and hand sequences cover the called-out corner cases.
module tb_feedback_frame_decoder;

    localparam int TMO = 4;
    int CONF [3] = '{1, 3, 2};

    logic       uart_clk = 1'b0;
    logic       reset;
    logic       data_valid;
    logic [7:0] data_receive;
    logic       script_mode;
    logic       tick_ms;

    logic       s_front [3];
    logic       s_hand  [3];
    logic       s_proc  [3];
    logic       s_mach  [3];
    logic       f_valid [3];
    logic       f_stale [3];
    logic       f_chg   [3];
    logic [7:0] f_cnt   [3];
    logic [7:0] e_cnt   [3];

    int vectors     = 0;
    int miscompares = 0;

    always #5 uart_clk = ~uart_clk;

    feedback_frame_decoder #(.CONFIRM(1), .TIMEOUT_MS(TMO)) dut0 (
        .uart_clk(uart_clk), .reset(reset), .data_valid(data_valid),
        .data_receive(data_receive), .script_mode(script_mode), .tick_ms(tick_ms),
        .sig_front(s_front[0]), .sig_hand(s_hand[0]), .sig_processing(s_proc[0]),
        .sig_machine(s_mach[0]), .feedback_valid(f_valid[0]), .feedback_stale(f_stale[0]),
        .feedback_changed(f_chg[0]), .frame_count(f_cnt[0]), .error_count(e_cnt[0]));

    feedback_frame_decoder #(.CONFIRM(3), .TIMEOUT_MS(TMO)) dut1 (
        .uart_clk(uart_clk), .reset(reset), .data_valid(data_valid),
        .data_receive(data_receive), .script_mode(script_mode), .tick_ms(tick_ms),
        .sig_front(s_front[1]), .sig_hand(s_hand[1]), .sig_processing(s_proc[1]),
        .sig_machine(s_mach[1]), .feedback_valid(f_valid[1]), .feedback_stale(f_stale[1]),
        .feedback_changed(f_chg[1]), .frame_count(f_cnt[1]), .error_count(e_cnt[1]));

    feedback_frame_decoder #(.CONFIRM(2), .TIMEOUT_MS(TMO)) dut2 (
        .uart_clk(uart_clk), .reset(reset), .data_valid(data_valid),
        .data_receive(data_receive), .script_mode(script_mode), .tick_ms(tick_ms),
        .sig_front(s_front[2]), .sig_hand(s_hand[2]), .sig_processing(s_proc[2]),
        .sig_machine(s_mach[2]), .feedback_valid(f_valid[2]), .feedback_stale(f_stale[2]),
        .feedback_changed(f_chg[2]), .frame_count(f_cnt[2]), .error_count(e_cnt[2]));

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0] cand;
        int         cnt;
        logic [3:0] outs;
        bit         valid;
        int         ticks;      // ms since last feedback byte, capped at TMO
        bit         chg;
        int         frame;
        int         err;
    } mdl_t;

    mdl_t m [3];
    bit   prev_dv;

    task automatic model_reset();
        prev_dv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m[i].cand = 4'd0; m[i].cnt = 0; m[i].outs = 4'd0; m[i].valid = 1'b0;
            m[i].ticks = 0; m[i].chg = 1'b0; m[i].frame = 0; m[i].err = 0;
        end
    endtask

    task automatic model_step(input logic dv, input logic [7:0] d, input logic sm, input logic tk);
        bit         take;
        logic [3:0] p;
        if (!reset) begin
            model_reset();
            return;
        end
        take    = dv && !prev_dv && !sm;
        prev_dv = dv;
        p       = d[5:2];
        for (int i = 0; i < 3; i++) begin
            m[i].chg = 1'b0;
            if (take && d[1:0] == 2'b01) begin
                m[i].frame = (m[i].frame + 1) % 256;
                m[i].ticks = 0;
                if (p == m[i].cand) begin
                    m[i].cnt = (m[i].cnt < CONF[i]) ? m[i].cnt + 1 : CONF[i];
                end else begin
                    m[i].cand = p;
                    m[i].cnt  = 1;
                end
                if (m[i].cnt == CONF[i]) begin
                    m[i].chg   = !m[i].valid || (p != m[i].outs);
                    m[i].outs  = p;
                    m[i].valid = 1'b1;
                end
            end else begin
                if (take && m[i].err < 255) m[i].err++;
                if (m[i].valid && tk && m[i].ticks < TMO) m[i].ticks++;
            end
        end
    endtask

    function automatic logic [22:0] mexp(int i);
        bit stale;
        stale = m[i].valid && (m[i].ticks >= TMO);
        return {m[i].outs, m[i].valid, stale, m[i].chg, 8'(m[i].frame), 8'(m[i].err)};
    endfunction

    function automatic logic [22:0] obs(int i);
        return {s_mach[i], s_proc[i], s_hand[i], s_front[i], f_valid[i], f_stale[i],
                f_chg[i], f_cnt[i], e_cnt[i]};
    endfunction

    // ---------------- checking / driving ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_models(input string tag);
        for (int i = 0; i < 3; i++) chk($sformatf("%s dut%0d", tag, i), 32'(obs(i)), 32'(mexp(i)));
    endtask

    task automatic step(input logic dv, input logic [7:0] d, input logic sm, input logic tk);
        data_valid = dv; data_receive = d; script_mode = sm; tick_ms = tk;
        @(posedge uart_clk);
        model_step(dv, d, sm, tk);
        #1;
        check_models("model");
    endtask

    task automatic do_reset();
        reset = 1'b0; data_valid = 1'b0; data_receive = 8'h00; script_mode = 1'b0; tick_ms = 1'b0;
        #1;
        model_reset();
        check_models("reset");
        @(posedge uart_clk);
        #1;
        reset = 1'b1;
    endtask

    // ---------------- directed table (CONFIRM=1 instance) ----------------
    typedef struct {
        logic       dv;
        logic [7:0] d;
        logic       sm;
        logic       tk;
        logic [3:0] nib;    // {machine, processing, hand, front}
        logic       v, s, c;
        logic [7:0] fc, ec;
    } vec_t;

    vec_t tbl [18];

    initial begin
        int  pulses;
        logic [7:0] b;
        logic [3:0] pool [4];

        tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[1]  = '{1'b1, 8'h2D, 1'b0, 1'b0, 4'hB, 1'b1, 1'b0, 1'b1, 8'd1, 8'd0};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'hB, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0};
        tbl[3]  = '{1'b1, 8'h2E, 1'b1, 1'b0, 4'hB, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'hB, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0};
        tbl[5]  = '{1'b1, 8'h2E, 1'b0, 1'b0, 4'hB, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'hB, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1};
        tbl[7]  = '{1'b1, 8'h2D, 1'b0, 1'b0, 4'hB, 1'b1, 1'b0, 1'b0, 8'd2, 8'd1};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'hB, 1'b1, 1'b0, 1'b0, 8'd2, 8'd1};
        tbl[9]  = '{1'b1, 8'h05, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b1, 8'd3, 8'd1};
        tbl[10] = '{1'b1, 8'h05, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 8'd3, 8'd1};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 8'd3, 8'd1};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 8'd3, 8'd1};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 8'd3, 8'd1};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 8'd3, 8'd1};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 8'd3, 8'd1};
        tbl[16] = '{1'b1, 8'h05, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 8'd4, 8'd1};
        tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 8'd4, 8'd1};

        pool[0] = 4'h1; pool[1] = 4'h2; pool[2] = 4'hB; pool[3] = 4'h0;

        do_reset();
        for (int k = 0; k < 18; k++) begin
            step(tbl[k].dv, tbl[k].d, tbl[k].sm, tbl[k].tk);
            chk($sformatf("table row %0d", k), 32'(obs(0)),
                32'({tbl[k].nib, tbl[k].v, tbl[k].s, tbl[k].c, tbl[k].fc, tbl[k].ec}));
        end

        // CONFIRM=3: 05 05 09 09 09 -> only the fifth byte commits (hand only).
        do_reset();
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            b = (k < 2) ? 8'h05 : 8'h09;
            step(1'b1, b, 1'b0, 1'b0);
            pulses += int'(f_chg[1]);
            if (k == 3) chk("confirm3 before 5th", 32'({s_mach[1], s_proc[1], s_hand[1], s_front[1]}), 32'h0);
            step(1'b0, 8'h00, 1'b0, 1'b0);
            pulses += int'(f_chg[1]);
        end
        chk("confirm3 nibble", 32'({s_mach[1], s_proc[1], s_hand[1], s_front[1]}), 32'h2);
        chk("confirm3 pulses", 32'(pulses), 32'd1);

        // data_valid held high counts once; then saturate error_count.
        do_reset();
        for (int k = 0; k < 10; k++) step(1'b1, 8'h05, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("held dv frame_count", 32'(f_cnt[0]), 32'd1);
        for (int k = 0; k < 300; k++) begin
            step(1'b1, 8'h02 | 8'(k[0]), 1'b0, 1'b0);
            step(1'b0, 8'h00, 1'b0, 1'b0);
        end
        chk("error_count saturate", 32'(e_cnt[0]), 32'd255);

        // Reset during the second byte of a CONFIRM=2 sequence.
        do_reset();
        step(1'b1, 8'h05, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        data_valid = 1'b1; data_receive = 8'h05;
        reset = 1'b0;
        #1;
        model_reset();
        chk("mid reset outputs", 32'(obs(2)), 32'h0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        step(1'b1, 8'h05, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("post reset no commit", 32'({s_front[2], f_valid[2], f_chg[2]}), 32'h0);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            if ($urandom_range(0, 3) == 0) b = 8'($urandom);
            else b = {2'($urandom), pool[$urandom_range(0, 3)], 2'b01};
            step(1'($urandom), b, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
